// File: rtl/sdu_averager_if.sv
// Sample stream bundle for the SDUltrasound coherent averager.
// I sits in the upper half of each word, Q in the lower half.
interface sdu_averager_if #(
  parameter int SWIDTH = 16
);
  logic [2*SWIDTH-1:0] sample_in;
  logic                strobe_in;
  logic [2*SWIDTH-1:0] sample_out;
  logic                strobe_out;

  modport master (
    output sample_in,
    output strobe_in,
    input  sample_out,
    input  strobe_out
  );

  modport slave (
    input  sample_in,
    input  strobe_in,
    output sample_out,
    output strobe_out
  );
endinterface

// File: rtl/sdu_averager.sv
// Coherent ping-pong averager behind the SDUltrasound sequence controller.
// One bank accumulates the current block while the other streams out.
module setting_reg #(
  parameter logic [7:0] my_addr  = 8'd0,
  parameter int         width    = 32,
  parameter logic [width-1:0] at_reset = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [31:0]      in,
  output logic [width-1:0] out,
  output logic             changed
);
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= at_reset;
      changed <= 1'b0;
    end else if (strobe && addr == my_addr) begin
      out     <= in[width-1:0];
      changed <= 1'b1;
    end else begin
      changed <= 1'b0;
    end
  end
endmodule

module sdu_averager_ram #(
  parameter int AW = 11,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [1<<AW];

  // Write-first on an address collision so back-to-back updates chain.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

module sdu_averager #(
  parameter int BASE     = 0,
  parameter int AWIDTH   = 11,
  parameter int SWIDTH   = 16,
  parameter int ACCWIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_stb,
  input  logic [7:0]    set_addr,
  input  logic [31:0]   set_data,
  input  logic          sdu_rx_en,
  input  logic          sdu_seq_done_strobe,
  input  logic          sdu_ave_done_strobe,
  sdu_averager_if.slave io,
  output logic          dump_active,
  output logic          overflow,
  output logic          overrun
);
  localparam int CW = AWIDTH + 1;
  localparam int DW = 2 * ACCWIDTH;
  localparam int EW = ACCWIDTH - SWIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_t;

  logic [31:0] shift_q;
  logic [31:0] clr_q;
  logic        shift_chg;
  logic        clr_stb;
  logic        unused_ok;

  setting_reg #(
    .my_addr (8'(BASE)),
    .width   (32),
    .at_reset(32'd0)
  ) u_shift (
    .clk    (clk),
    .rst    (reset),
    .strobe (set_stb),
    .addr   (set_addr),
    .in     (set_data),
    .out    (shift_q),
    .changed(shift_chg)
  );

  setting_reg #(
    .my_addr (8'(BASE + 1)),
    .width   (32),
    .at_reset(32'd0)
  ) u_clr (
    .clk    (clk),
    .rst    (reset),
    .strobe (set_stb),
    .addr   (set_addr),
    .in     (set_data),
    .out    (clr_q),
    .changed(clr_stb)
  );

  assign unused_ok = ^{shift_q[31:5], clr_q, shift_chg};

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              first_pass;
  logic              acc_bank;
  logic              hit;
  logic              accept;
  logic              seq_end;

  logic              s1_valid;
  logic              s1_bank;
  logic              s1_first;
  logic [AWIDTH-1:0] s1_addr;
  logic [SWIDTH-1:0] s1_i;
  logic [SWIDTH-1:0] s1_q;

  state_t            state;
  logic [CW-1:0]     dump_len;
  logic [AWIDTH-1:0] dump_addr;
  logic              dump_bank;
  logic              p1_valid;
  logic              p1_bank;

  logic [DW-1:0]       rd_data [2];
  logic [DW-1:0]       acc_old;
  logic [DW-1:0]       wr_data;
  logic [DW-1:0]       dump_word;
  logic [ACCWIDTH-1:0] ext_i;
  logic [ACCWIDTH-1:0] ext_q;

  // cnt carries one extra bit so a full sequence is distinguishable.
  assign hit     = io.strobe_in & sdu_rx_en;
  assign accept  = hit & ~cnt[AWIDTH];
  assign seq_end = sdu_seq_done_strobe | sdu_ave_done_strobe;
  assign cnt_inc = cnt + {{AWIDTH{1'b0}}, accept};

  assign acc_old = rd_data[s1_bank];
  assign ext_i   = {{EW{s1_i[SWIDTH-1]}}, s1_i};
  assign ext_q   = {{EW{s1_q[SWIDTH-1]}}, s1_q};
  assign wr_data = s1_first ? {ext_i, ext_q}
                 : {acc_old[DW-1:ACCWIDTH] + ext_i,
                    acc_old[ACCWIDTH-1:0] + ext_q};

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [AWIDTH-1:0] raddr;
      logic              we;
      assign raddr = (acc_bank == 1'(b)) ? cnt[AWIDTH-1:0]
                                         : dump_addr;
      assign we    = s1_valid && (s1_bank == 1'(b));
      sdu_averager_ram #(
        .AW(AWIDTH),
        .DW(DW)
      ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(s1_addr),
        .wdata(wr_data),
        .raddr(raddr),
        .rdata(rd_data[b])
      );
    end
  endgenerate

  function automatic logic [SWIDTH-1:0] sat(
    input logic [ACCWIDTH-1:0] a,
    input logic [4:0]          sh
  );
    logic signed [ACCWIDTH-1:0] s;
    s = $signed(a) >>> sh;
    if (&s[ACCWIDTH-1:SWIDTH-1] || ~|s[ACCWIDTH-1:SWIDTH-1])
      return s[SWIDTH-1:0];
    return s[ACCWIDTH-1] ? {1'b1, {(SWIDTH-1){1'b0}}}
                         : {1'b0, {(SWIDTH-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      first_pass <= 1'b1;
      acc_bank   <= 1'b0;
      overflow   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_bank    <= 1'b0;
      s1_first   <= 1'b0;
      s1_addr    <= '0;
      s1_i       <= '0;
      s1_q       <= '0;
    end else begin
      s1_valid <= accept;
      s1_bank  <= acc_bank;
      s1_first <= first_pass;
      s1_addr  <= cnt[AWIDTH-1:0];
      s1_i     <= io.sample_in[2*SWIDTH-1:SWIDTH];
      s1_q     <= io.sample_in[SWIDTH-1:0];
      cnt      <= seq_end ? '0 : cnt_inc;
      if (sdu_ave_done_strobe) begin
        first_pass <= 1'b1;
        acc_bank   <= ~acc_bank;
      end else if (sdu_seq_done_strobe) begin
        first_pass <= 1'b0;
      end
      if (hit && cnt[AWIDTH])
        overflow <= 1'b1;
      else if (clr_stb)
        overflow <= 1'b0;
    end
  end

  assign dump_word   = rd_data[p1_bank];
  assign dump_active = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      dump_len      <= '0;
      dump_addr     <= '0;
      dump_bank     <= 1'b0;
      p1_valid      <= 1'b0;
      p1_bank       <= 1'b0;
      overrun       <= 1'b0;
      io.strobe_out <= 1'b0;
      io.sample_out <= '0;
    end else begin
      p1_valid      <= 1'b0;
      p1_bank       <= dump_bank;
      io.strobe_out <= p1_valid;
      if (p1_valid)
        io.sample_out <= {sat(dump_word[DW-1:ACCWIDTH], shift_q[4:0]),
                          sat(dump_word[ACCWIDTH-1:0], shift_q[4:0])};
      if (clr_stb)
        overrun <= 1'b0;
      // A handoff preempts everything, including the in-flight beat.
      if (sdu_ave_done_strobe) begin
        if (state != S_IDLE)
          overrun <= 1'b1;
        io.strobe_out <= 1'b0;
        dump_len      <= cnt_inc;
        dump_addr     <= '0;
        dump_bank     <= acc_bank;
        state         <= (cnt_inc != '0) ? S_WAIT : S_IDLE;
      end else begin
        unique case (state)
          S_IDLE:  state <= S_IDLE;
          S_WAIT:  state <= S_READ;
          S_READ: begin
            p1_valid  <= 1'b1;
            dump_addr <= dump_addr + AWIDTH'(1);
            if ({1'b0, dump_addr} == dump_len - CW'(1))
              state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (!p1_valid)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdu_averager.sv
// Directed bench for sdu_averager: a depth-32 unit for the main flow
// and a depth-8 unit sharing its stimulus for the overflow boundary.
module tb_sdu_averager;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        rx_en = 1'b0;
  logic        seq_done = 1'b0;
  logic        ave_done = 1'b0;
  logic        strobe_in = 1'b0;
  logic [31:0] sample_in = '0;
  logic        act_a, ovf_a, ovr_a;
  logic        act_b, ovf_b, ovr_b;
  int          errors = 0;
  int          checks = 0;

  logic        a_stb [64];
  logic        b_stb [64];
  logic        a_act [64];
  logic [31:0] a_dat [64];
  logic [31:0] b_dat [64];
  int          a_first, a_cnt, b_first, b_cnt;

  always #5 clk = ~clk;

  sdu_averager_if #(.SWIDTH(16)) ifa ();
  sdu_averager_if #(.SWIDTH(16)) ifb ();

  assign ifa.sample_in = sample_in;
  assign ifa.strobe_in = strobe_in;
  assign ifb.sample_in = sample_in;
  assign ifb.strobe_in = strobe_in;

  sdu_averager #(
    .BASE(0), .AWIDTH(5), .SWIDTH(16), .ACCWIDTH(32)
  ) dut_a (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sdu_rx_en(rx_en),
    .sdu_seq_done_strobe(seq_done),
    .sdu_ave_done_strobe(ave_done),
    .io(ifa),
    .dump_active(act_a), .overflow(ovf_a), .overrun(ovr_a)
  );

  sdu_averager #(
    .BASE(0), .AWIDTH(3), .SWIDTH(16), .ACCWIDTH(32)
  ) dut_b (
    .clk(clk), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sdu_rx_en(rx_en),
    .sdu_seq_done_strobe(seq_done),
    .sdu_ave_done_strobe(ave_done),
    .io(ifb),
    .dump_active(act_b), .overflow(ovf_b), .overrun(ovr_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic rx,
                       input logic sd, input logic ad,
                       input logic [15:0] i, input logic [15:0] q);
    strobe_in = stb;
    rx_en     = rx;
    seq_done  = sd | ad;
    ave_done  = ad;
    sample_in = {i, q};
    tick;
    strobe_in = 1'b0;
    rx_en     = 1'b0;
    seq_done  = 1'b0;
    ave_done  = 1'b0;
  endtask

  task automatic setreg(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick;
    set_stb  = 1'b0;
  endtask

  // Log index j is the number of edges after the ave_done edge.
  task automatic capture(input int n);
    a_cnt = 0; b_cnt = 0; a_first = -1; b_first = -1;
    for (int j = 0; j < 64; j++) begin
      a_stb[j] = 1'b0; b_stb[j] = 1'b0; a_act[j] = 1'b0;
      a_dat[j] = '0;   b_dat[j] = '0;
    end
    for (int j = 1; j <= n; j++) begin
      tick;
      a_stb[j] = ifa.strobe_out;
      a_dat[j] = ifa.sample_out;
      a_act[j] = act_a;
      b_stb[j] = ifb.strobe_out;
      b_dat[j] = ifb.sample_out;
      if (a_stb[j]) begin
        a_cnt++;
        if (a_first < 0) a_first = j;
      end
      if (b_stb[j]) begin
        b_cnt++;
        if (b_first < 0) b_first = j;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick;
  endtask

  initial begin
    for (int j = 0; j < 3; j++) tick;
    reset = 1'b0;
    tick;
    check("reset_a", {ifa.strobe_out, ifa.sample_out, act_a, ovf_a, ovr_a}, '0);
    check("reset_b", {ifb.strobe_out, ifb.sample_out, act_b, ovf_b, ovr_b}, '0);

    // Gating and overflow: 10 accepted, 3 gated off, depth-8 unit overflows
    for (int k = 0; k < 8; k++) drive(1, 1, 0, 0, 16'd1, 16'd2);
    check("ovf_b_at_depth", ovf_b, 1'b0);
    drive(1, 0, 0, 0, 16'd1000, 16'd1000);
    drive(1, 1, 0, 0, 16'd1, 16'd2);
    drive(1, 0, 0, 0, 16'd1000, 16'd1000);
    drive(1, 1, 0, 0, 16'd1, 16'd2);
    drive(1, 0, 0, 0, 16'd1000, 16'd1000);
    check("ovf_b_set", ovf_b, 1'b1);
    check("ovf_a_clear", ovf_a, 1'b0);
    drive(0, 0, 0, 1, 16'd0, 16'd0);
    capture(20);
    check("gate_a_len", a_cnt, 10);
    check("gate_a_first", a_first, 3);
    check("gate_a_val", a_dat[12], 32'h0001_0002);
    check("ovf_b_len", b_cnt, 8);
    check("ovf_b_val", b_dat[10], 32'h0001_0002);
    setreg(8'd1, 32'd0);
    tick;
    check("ovf_b_cleared", ovf_b, 1'b0);

    // Basic average: 4 sequences of (k,-k), shift 2
    setreg(8'd0, 32'd2);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 8; k++) drive(1, 1, 0, 0, 16'(k), 16'(-k));
      if (s < 3) drive(0, 0, 1, 0, 16'd0, 16'd0);
    end
    drive(0, 0, 0, 1, 16'd0, 16'd0);
    capture(16);
    check("basic_first", a_first, 3);
    check("basic_len", a_cnt, 8);
    check("basic_active", a_act[3], 1'b1);
    check("basic_done", a_act[16], 1'b0);
    for (int k = 0; k < 8; k++)
      check($sformatf("basic_val%0d", k), a_dat[3+k], {16'(k), 16'(-k)});

    // Saturation, with one in-range index alongside
    setreg(8'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      drive(1, 1, 0, 0, 16'h7FFF, 16'h8000);
      drive(1, 1, 0, 0, 16'h7FFF, 16'h8000);
      drive(1, 1, (s == 0), (s == 1), 16'h0001, 16'hFFFF);
    end
    capture(10);
    check("sat_len", a_cnt, 3);
    check("sat_val0", a_dat[3], 32'h7FFF_8000);
    check("sat_val1", a_dat[4], 32'h7FFF_8000);
    check("sat_inrange", a_dat[5], 32'h0002_FFFE);

    // First-pass overwrite; block B accumulates while A streams
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) drive(1, 1, 0, 0, 16'd100, 16'd100);
      drive(0, 0, (s < 2), (s == 2), 16'd0, 16'd0);
    end
    fork
      capture(16);
      begin
        for (int s = 0; s < 3; s++) begin
          for (int k = 0; k < 4; k++) drive(1, 1, 0, 0, 16'd5, 16'd5);
          if (s < 2) drive(0, 0, 1, 0, 16'd0, 16'd0);
        end
      end
    join
    check("fpA_len", a_cnt, 4);
    check("fpA_val", a_dat[6], 32'h012C_012C);
    drive(0, 0, 0, 1, 16'd0, 16'd0);
    capture(12);
    check("fpB_len", a_cnt, 4);
    check("fpB_val0", a_dat[3], 32'h000F_000F);
    check("fpB_val3", a_dat[6], 32'h000F_000F);

    // Coincident samples on seq_done and on ave_done
    drive(1, 1, 0, 0, 16'd1, 16'd1);
    drive(1, 1, 0, 0, 16'd2, 16'd2);
    drive(1, 1, 1, 0, 16'd3, 16'd3);
    drive(1, 1, 0, 0, 16'd10, 16'd10);
    drive(1, 1, 0, 0, 16'd20, 16'd20);
    drive(1, 1, 0, 1, 16'd30, 16'd30);
    capture(10);
    check("coinc_len", a_cnt, 3);
    check("coinc_idx0", a_dat[3], 32'h000B_000B);
    check("coinc_idx2", a_dat[5], 32'h0021_0021);

    // Overrun: new handoff two beats into a 16-sample dump
    for (int k = 0; k < 16; k++) drive(1, 1, 0, 0, 16'(100 + k), 16'(k));
    drive(0, 0, 0, 1, 16'd0, 16'd0);
    fork
      capture(16);
      begin
        drive(1, 1, 0, 0, 16'd7, 16'd7);
        drive(1, 1, 0, 0, 16'd8, 16'd8);
        drive(0, 0, 0, 0, 16'd0, 16'd0);
        drive(0, 0, 0, 0, 16'd0, 16'd0);
        drive(1, 1, 0, 1, 16'd9, 16'd9);
      end
    join
    check("ovr_flag", ovr_a, 1'b1);
    check("ovr_first", a_first, 3);
    check("ovr_old1", a_dat[4], 32'h0065_0001);
    check("ovr_gap", a_stb[5], 1'b0);
    check("ovr_len", a_cnt, 5);
    check("ovr_new0", a_dat[8], 32'h0007_0007);
    check("ovr_new2", a_dat[10], 32'h0009_0009);
    check("ovr_idle", a_act[16], 1'b0);

    // Reset in the middle of a dump
    for (int k = 0; k < 4; k++) drive(1, 1, 0, 0, 16'd50, 16'd50);
    drive(0, 0, 0, 1, 16'd0, 16'd0);
    idle(3);
    check("mid_dump_live", ifa.strobe_out, 1'b1);
    reset = 1'b1;
    tick;
    check("rst_a", {ifa.strobe_out, act_a, ovf_a, ovr_a}, '0);
    check("rst_b", {ifb.strobe_out, act_b, ovf_b, ovr_b}, '0);
    reset = 1'b0;
    capture(10);
    check("rst_quiet", a_cnt, 0);

    // Empty block hands off nothing
    drive(0, 0, 0, 1, 16'd0, 16'd0);
    capture(8);
    check("empty_len", a_cnt, 0);
    check("empty_act", a_act[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
